// File: rtl/key_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_cmd_sequencer                                            |
// | Description : Assembles filtered PS/2 key codes into single-letter         |
// |               commands with an optional 1-2 digit argument. Enter issues   |
// |               the command, which is held until the consumer acknowledges.  |
// |               Rejected sequences give a one-cycle err pulse.               |
// | Ports       : CLK        system clock, rising edge                         |
// |               reset      asynchronous, active-low reset                    |
// |               rx_tick    strobe, din holds a completed key                 |
// |               din[7:0]   PS/2 scan code                                    |
// |               cmd_ack    consumer accepts the presented command            |
// |               cmd_valid  command presented, held until cmd_ack             |
// |               cmd_code   H=0 A=1 P=2 I=3 Y=4 N=5 G=6 R=7                   |
// |               cmd_arg    numeric argument 0..99 (0 when none)              |
// |               err        one-cycle pulse on a rejected key                 |
// |               busy       sequencer is not idle                             |
// | Options     : define KEY_TIMEOUT_EN to abandon a partial sequence after    |
// |               TIMEOUT_CYC cycles without a key.                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module key_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       rx_tick,
   input  logic [7:0] din,
   input  logic       cmd_ack,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic [6:0] cmd_arg,
   output logic       err,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_ARG1  = 3'd2,
      S_ARG2  = 3'd3,
      S_ISSUE = 3'd4
   } state_t;

   localparam logic [2:0] C_CMD_A = 3'd1;
   localparam logic [2:0] C_CMD_P = 3'd2;

   state_t     state_q, state_d;
   logic [2:0] code_q, code_d;
   logic [6:0] arg_q, arg_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;
   logic       busy_q, busy_d;
   logic       timeout;

   // Scan-code decode
   logic       is_digit, is_letter, is_enter;
   logic [3:0] digit_val;
   logic [2:0] letter_idx;

   always_comb begin
      is_digit   = 1'b0;
      is_letter  = 1'b0;
      is_enter   = 1'b0;
      digit_val  = 4'd0;
      letter_idx = 3'd0;
      case (din)
         8'h45: begin is_digit = 1'b1;  digit_val = 4'd0; end
         8'h16: begin is_digit = 1'b1;  digit_val = 4'd1; end
         8'h1E: begin is_digit = 1'b1;  digit_val = 4'd2; end
         8'h26: begin is_digit = 1'b1;  digit_val = 4'd3; end
         8'h25: begin is_digit = 1'b1;  digit_val = 4'd4; end
         8'h2E: begin is_digit = 1'b1;  digit_val = 4'd5; end
         8'h36: begin is_digit = 1'b1;  digit_val = 4'd6; end
         8'h3D: begin is_digit = 1'b1;  digit_val = 4'd7; end
         8'h3E: begin is_digit = 1'b1;  digit_val = 4'd8; end
         8'h46: begin is_digit = 1'b1;  digit_val = 4'd9; end
         8'h33: begin is_letter = 1'b1; letter_idx = 3'd0; end
         8'h1C: begin is_letter = 1'b1; letter_idx = 3'd1; end
         8'h4D: begin is_letter = 1'b1; letter_idx = 3'd2; end
         8'h43: begin is_letter = 1'b1; letter_idx = 3'd3; end
         8'h35: begin is_letter = 1'b1; letter_idx = 3'd4; end
         8'h31: begin is_letter = 1'b1; letter_idx = 3'd5; end
         8'h34: begin is_letter = 1'b1; letter_idx = 3'd6; end
         8'h2D: begin is_letter = 1'b1; letter_idx = 3'd7; end
         8'h5A: is_enter = 1'b1;
         default: ;
      endcase
   end

`ifdef KEY_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_seq;

   assign in_seq = (state_q == S_CMD) || (state_q == S_ARG1) || (state_q == S_ARG2);
   // Every state entry happens on a key, so clearing on any rx_tick also
   // covers the clear-on-entry case.
   assign cnt_d   = (!in_seq || rx_tick) ? '0 : cnt_q + 1'b1;
   // A key arriving on the expiry cycle wins over the timeout.
   assign timeout = in_seq && !rx_tick && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   // Partial sequences wait indefinitely; TIMEOUT_CYC has no effect here.
   assign timeout = 1'b0;
   if (TIMEOUT_CYC == 0) begin : g_timeout_unused
   end
`endif

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      arg_d   = arg_q;
      valid_d = valid_q;
      err_d   = 1'b0;

      if (state_q == S_ISSUE) begin
         // Keys are dropped while a command is presented; only ack matters.
         if (cmd_ack) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      end else if (rx_tick && is_letter) begin
         // A letter always (re)starts a sequence, from any non-issue state.
         state_d = S_CMD;
         code_d  = letter_idx;
         arg_d   = 7'd0;
      end else if (rx_tick && (is_digit || is_enter)) begin
         case (state_q)
            S_CMD: begin
               if ((code_q == C_CMD_A) || (code_q == C_CMD_P)) begin
                  if (is_digit) begin
                     state_d = S_ARG1;
                     arg_d   = {3'b000, digit_val};
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else if (is_enter) begin
                  state_d = S_ISSUE;
                  valid_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_ARG1: begin
               if (is_digit) begin
                  state_d = S_ARG2;
                  arg_d   = (arg_q * 7'd10) + {3'b000, digit_val};
               end else begin
                  state_d = S_ISSUE;
                  valid_d = 1'b1;
               end
            end
            S_ARG2: begin
               if (is_enter) begin
                  state_d = S_ISSUE;
                  valid_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: err_d = 1'b1;  // S_IDLE: no command to attach to
         endcase
      end else if (timeout) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         code_q  <= 3'd0;
         arg_q   <= 7'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         arg_q   <= arg_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign cmd_valid = valid_q;
   assign cmd_code  = code_q;
   assign cmd_arg   = arg_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_cmd_sequencer                                         |
// | Description : Self-checking bench for key_cmd_sequencer: directed key      |
// |               scenarios plus random key streams against a reference model. |
// |               Honours KEY_TIMEOUT_EN the same way as the design.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_key_cmd_sequencer;

   localparam int TO = 16;
   localparam int K_OTHER = 0, K_DIGIT = 1, K_LETTER = 2, K_ENTER = 3;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       rx_tick = 1'b0;
   logic [7:0] din = 8'h00;
   logic       cmd_ack = 1'b0;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic [6:0] cmd_arg;
   logic       err;
   logic       busy;

   key_cmd_sequencer #(.TIMEOUT_CYC(TO)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .rx_tick   (rx_tick),
      .din       (din),
      .cmd_ack   (cmd_ack),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .cmd_arg   (cmd_arg),
      .err       (err),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   logic [7:0] digit_codes  [0:9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] letter_codes [0:7] = '{8'h33, 8'h1C, 8'h4D, 8'h43,
                                      8'h35, 8'h31, 8'h34, 8'h2D};

   // Reference model: the sequence typed so far is a command letter plus a
   // list of digits; the argument is the decimal value of that list.
   bit m_seq, m_issue, m_valid, m_err, m_busy;
   int m_code, m_arg, m_idle;
   int m_digs[$];

   function automatic int classify(input logic [7:0] c, output int v);
      v = 0;
      if (c == 8'h5A) return K_ENTER;
      for (int i = 0; i < 10; i++) if (digit_codes[i] == c) begin v = i; return K_DIGIT; end
      for (int i = 0; i < 8; i++) if (letter_codes[i] == c) begin v = i; return K_LETTER; end
      return K_OTHER;
   endfunction

   task automatic model_reset();
      m_seq = 0; m_issue = 0; m_valid = 0; m_err = 0; m_busy = 0;
      m_code = 0; m_arg = 0; m_idle = 0;
      m_digs.delete();
   endtask

   task automatic model_edge(input bit tick, input logic [7:0] code, input bit ack);
      int kind, val;
      bit needs_arg;
      m_err = 0;
      kind = classify(code, val);
      needs_arg = (m_code == 1) || (m_code == 2);
      if (m_issue) begin
         if (ack) begin m_issue = 0; m_valid = 0; end
      end else if (tick) begin
         m_idle = 0;
         if (kind == K_LETTER) begin
            m_seq = 1; m_code = val; m_arg = 0; m_digs.delete();
         end else if (kind == K_DIGIT) begin
            if (!m_seq) m_err = 1;
            else if (!needs_arg || m_digs.size() == 2) begin m_err = 1; m_seq = 0; end
            else begin
               m_digs.push_back(val);
               m_arg = 0;
               foreach (m_digs[i]) m_arg = m_arg * 10 + m_digs[i];
            end
         end else if (kind == K_ENTER) begin
            if (!m_seq) m_err = 1;
            else if (needs_arg && m_digs.size() == 0) begin m_err = 1; m_seq = 0; end
            else begin m_seq = 0; m_issue = 1; m_valid = 1; end
         end
      end else if (m_seq) begin
`ifdef KEY_TIMEOUT_EN
         if (m_idle == TO - 1) begin m_err = 1; m_seq = 0; end
         else m_idle++;
`endif
      end
      m_busy = m_seq || m_issue;
   endtask

   // One clock: present inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input bit tick, input logic [7:0] code, input bit ack);
      rx_tick = tick; din = code; cmd_ack = ack;
      model_edge(tick, code, ack);
      @(posedge CLK); #1;
      rx_tick = 1'b0; cmd_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; rx_tick = 1'b0; cmd_ack = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
      checks++; if (cmd_code !== 3'd0)  begin errors++; $display("FAIL reset_code got=%0d exp=0", cmd_code); end
      checks++; if (cmd_arg !== 7'd0)   begin errors++; $display("FAIL reset_arg got=%0d exp=0", cmd_arg); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b1;
   endtask

   task automatic test_arg_command();
      step(1, 8'h1C, 0); step(1, 8'h1E, 0); step(1, 8'h2E, 0);
      checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL arg_before_enter valid=%b busy=%b exp valid=0 busy=1", cmd_valid, busy); end
      step(1, 8'h5A, 0);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL arg_valid got=%b exp=1", cmd_valid); end
      checks++; if (cmd_code !== 3'd1)  begin errors++; $display("FAIL arg_code got=%0d exp=1", cmd_code); end
      checks++; if (cmd_arg !== 7'd25)  begin errors++; $display("FAIL arg_value got=%0d exp=25", cmd_arg); end
      step(0, 8'h00, 1);
      checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arg_ack valid=%b busy=%b exp 0 0", cmd_valid, busy); end
   endtask

   task automatic test_hold_issue();
      int bad;
      bad = 0;
      step(1, 8'h33, 0); step(1, 8'h5A, 0);
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd0 || cmd_arg !== 7'd0) begin errors++; $display("FAIL hold_issue valid=%b code=%0d arg=%0d exp 1 0 0", cmd_valid, cmd_code, cmd_arg); end
      for (int i = 0; i < 20; i++) begin
         step(i == 10, 8'h16, 0);
         if (cmd_valid !== 1'b1 || cmd_code !== 3'd0 || cmd_arg !== 7'd0 || err !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
      step(1, 8'h16, 1);
      checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL ack_with_key valid=%b busy=%b err=%b exp 0 0 0", cmd_valid, busy, err); end
      step(0, 8'h00, 1);
      checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ack_outside_issue valid=%b busy=%b exp 0 0", cmd_valid, busy); end
   endtask

   task automatic test_third_digit();
      int valid_seen, err_seen;
      valid_seen = 0; err_seen = 0;
      step(1, 8'h4D, 0); valid_seen += cmd_valid; err_seen += err;
      step(1, 8'h16, 0); valid_seen += cmd_valid; err_seen += err;
      step(1, 8'h1E, 0); valid_seen += cmd_valid; err_seen += err;
      step(1, 8'h26, 0);
      checks++; if (err !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL third_digit err=%b busy=%b valid=%b exp 1 0 0", err, busy, cmd_valid); end
      step(0, 8'h00, 0); valid_seen += cmd_valid;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_width got=%b exp=0", err); end
      checks++; if (valid_seen !== 0 || err_seen !== 0) begin errors++; $display("FAIL third_digit_path valid_seen=%0d err_seen=%0d exp 0 0", valid_seen, err_seen); end
   endtask

   task automatic test_restart();
      int err_seen;
      err_seen = 0;
      step(1, 8'h1C, 0); err_seen += err;
      step(1, 8'h2D, 0); err_seen += err;
      step(1, 8'h5A, 0); err_seen += err;
      checks++; if (err_seen !== 0) begin errors++; $display("FAIL restart_err count=%0d exp=0", err_seen); end
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd7 || cmd_arg !== 7'd0) begin errors++; $display("FAIL restart_cmd valid=%b code=%0d arg=%0d exp 1 7 0", cmd_valid, cmd_code, cmd_arg); end
      step(0, 8'h00, 1);
   endtask

   task automatic test_timeout();
      int err_seen;
      err_seen = 0;
      step(1, 8'h1C, 0);
`ifdef KEY_TIMEOUT_EN
      for (int i = 1; i < TO; i++) begin step(0, 8'h00, 0); err_seen += err; end
      step(0, 8'h00, 0);
      checks++; if (err !== 1'b1 || busy !== 1'b0 || err_seen !== 0) begin errors++; $display("FAIL timeout err=%b busy=%b early_err=%0d exp 1 0 0", err, busy, err_seen); end
      step(0, 8'h00, 0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_width err=%b exp=0", err); end
`else
      for (int i = 0; i < 3 * TO; i++) begin step(0, 8'h00, 0); err_seen += err; end
      checks++; if (busy !== 1'b1 || err_seen !== 0) begin errors++; $display("FAIL no_timeout busy=%b err_seen=%0d exp 1 0", busy, err_seen); end
      step(1, 8'h5A, 0);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL enter_without_arg err=%b busy=%b exp 1 0", err, busy); end
`endif
   endtask

   task automatic test_async_reset();
      step(1, 8'h33, 0); step(1, 8'h5A, 0);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", cmd_valid); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({cmd_valid, cmd_code, cmd_arg, err, busy} !== 13'd0) begin errors++; $display("FAIL async_reset valid=%b code=%0d arg=%0d err=%b busy=%b exp all 0", cmd_valid, cmd_code, cmd_arg, err, busy); end
      #2 reset = 1'b1;
      model_reset();
      step(1, 8'h5A, 0);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_enter err=%b busy=%b exp 1 0", err, busy); end
      step(0, 8'h00, 0);
   endtask

   task automatic test_random();
      logic [12:0] got, exp;
      logic [7:0]  code;
      int r;
      do_reset();
      reset = 1'b1;
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         if (r < 35)      code = letter_codes[$urandom_range(0, 7)];
         else if (r < 70) code = digit_codes[$urandom_range(0, 9)];
         else if (r < 85) code = 8'h5A;
         else             code = 8'($urandom);
         step($urandom_range(0, 99) < 60, code, $urandom_range(0, 99) < 25);
         got = {cmd_valid, cmd_code, cmd_arg, err, busy};
         exp = {m_valid, 3'(m_code), 7'(m_arg), m_err, m_busy};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random step=%0d got valid=%b code=%0d arg=%0d err=%b busy=%b exp valid=%b code=%0d arg=%0d err=%b busy=%b",
                     n, got[12], got[11:9], got[8:2], got[1], got[0], exp[12], exp[11:9], exp[8:2], exp[1], exp[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_arg_command();
      test_hold_issue();
      test_third_digit();
      test_restart();
      test_timeout();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/key_cmd_sequencer.md
KEY_CMD_SEQUENCER -- requirements
Module: key_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000000, is the idle-key timeout in CLK cycles mid-sequence.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 rx_tick  in  1  one-cycle strobe from the release-filter: scan code on din is a completed key.
REQ-005 din  in  8  PS/2 scan code, valid when rx_tick=1.
REQ-006 cmd_ack  in  1  consumer accepts the presented command.
REQ-007 cmd_valid  out  1  registered; command presented, held until cmd_ack.
REQ-008 cmd_code  out  3  registered command index: H=0 A=1 P=2 I=3 Y=4 N=5 G=6 R=7.
REQ-009 cmd_arg  out  7  registered numeric argument, 0..99; 0 for no-argument commands.
REQ-010 err  out  1  registered one-cycle pulse on a rejected sequence.
REQ-011 busy  out  1  registered; 1 in any state other than S_IDLE.

Function
REQ-012 Digit codes shall be 45,16,1E,26,25,2E,36,3D,3E,46 (hex) = 0..9; letter codes 33,1C,4D,43,35,31,34,2D = H,A,P,I,Y,N,G,R; enter 5A; all other codes shall be ignored with no state change.
REQ-013 FSM states: S_IDLE, S_CMD, S_ARG1, S_ARG2, S_ISSUE.
REQ-014 S_IDLE: letter -> S_CMD, latch cmd index, clear arg; digit or enter -> err pulse, stay S_IDLE.
REQ-015 Commands A and P shall require 1-2 digits; all others shall take no digits.
REQ-016 S_CMD: digit on A/P -> S_ARG1, arg=digit; digit on other command -> err, S_IDLE; enter on non-A/P -> S_ISSUE; enter on A/P -> err, S_IDLE.
REQ-017 S_ARG1: digit -> S_ARG2, arg=arg*10+digit (7-bit, max 99); enter -> S_ISSUE.
REQ-018 S_ARG2: enter -> S_ISSUE; digit (third) -> err, S_IDLE.
REQ-019 A letter in S_CMD, S_ARG1 or S_ARG2 shall restart: latch new letter, clear arg, go S_CMD, no err.
REQ-020 Entering S_ISSUE shall set cmd_valid=1 on the same edge that consumes enter (latency 1 cycle from the enter tick); cmd_code/cmd_arg stable while cmd_valid=1.
REQ-021 S_ISSUE: all rx_tick ignored; cmd_ack=1 -> cmd_valid=0, S_IDLE on next edge.
REQ-022 rx_tick and cmd_ack in the same S_ISSUE cycle: ack processed, key dropped.
REQ-023 cmd_ack outside S_ISSUE shall be ignored.
REQ-024 err shall be exactly one cycle wide per rejected key; cmd_code/cmd_arg hold last values after err.

Reset
REQ-025 reset=0 shall immediately force S_IDLE, cmd_valid=0, cmd_code=0, cmd_arg=0, err=0, busy=0, timeout counter=0, including mid-sequence and during S_ISSUE.
REQ-026 After reset release, the first accepted event shall be the next rx_tick.

Configuration
REQ-027 Macro KEY_TIMEOUT_EN defined: counter runs in S_CMD/S_ARG1/S_ARG2, clears on each rx_tick and on state entry; reaching TIMEOUT_CYC-1 -> err pulse, S_IDLE.
REQ-028 KEY_TIMEOUT_EN undefined: no counter logic; partial sequences wait indefinitely; TIMEOUT_CYC unused.
REQ-029 S_ISSUE shall never time out in either build.

Verification
REQ-030 Keys A(1C),2(1E),5(2E),enter(5A) -> cmd_valid=1 one cycle after enter tick, cmd_code=1, cmd_arg=25; cmd_ack -> cmd_valid=0, busy=0.
REQ-031 Keys H(33),enter -> cmd_code=0, cmd_arg=0; hold cmd_ack=0 for 20 cycles, send 16 -> cmd_valid stays 1, outputs unchanged.
REQ-032 Keys P,1,2,3 -> single err pulse on third digit tick+1, busy=0, cmd_valid never 1.
REQ-033 Keys A, then R(2D), enter -> no err, cmd_code=7, cmd_arg=0.
REQ-034 KEY_TIMEOUT_EN, TIMEOUT_CYC=16: key A then no keys -> err pulse 16 cycles later, busy=0; build without macro -> busy stays 1.
REQ-035 reset=0 asserted while cmd_valid=1 -> all outputs 0 asynchronously; after release, keys enter -> err.
